// File: rtl/lsu_bank_xbar.sv
// Four-LSU to four-bank 1R1W SRAM crossbar with registered read return and sticky per-bank conflict flags.
// Optional round-robin bank arbitration is compiled in with LSU_XBAR_RR_ARB_EN.
module lsu_bank_xbar #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*3-1:0]            r_req,
  input  logic [4*(DATA_W+3)-1:0]   w_req,
  input  logic [4*(ADDR_W+2)-1:0]   addr_bus,
  output logic [4*(DATA_W+1)-1:0]   cbg_to_lsu,
  output logic [3:0]                conflict_flag,
  input  logic                      conflict_clr
);

  localparam int RW = $clog2(DEPTH);
  localparam int AW = ADDR_W + 2;
  localparam int WQ = DATA_W + 3;
  localparam int OQ = DATA_W + 1;

  logic [3:0]              ren;
  logic [3:0]              wen;
  logic [3:0][1:0]         r_sel;
  logic [3:0][1:0]         w_sel;
  logic [3:0][DATA_W-1:0]  wdata;
  logic [3:0][RW-1:0]      row;
  logic                    unused_addr_bits;

  logic [3:0][3:0]         r_grant;      // [bank][port]
  logic [3:0]              conflict_now;
  logic [3:0][DATA_W-1:0]  bank_rdata;

  logic [3:0]              rd_valid_reg;
  logic [3:0]              rd_valid_next;
  logic [3:0][1:0]         rd_bank_reg;
  logic [3:0]              conflict_flag_reg;

  // Upper address bits beyond the row index are deliberately ignored.
  assign unused_addr_bits = ^addr_bus;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_port
      assign ren[gi]   = r_req[3*gi];
      assign r_sel[gi] = r_req[3*gi+1 +: 2];
      assign wdata[gi] = w_req[WQ*gi +: DATA_W];
      assign wen[gi]   = w_req[WQ*gi + DATA_W];
      assign w_sel[gi] = w_req[WQ*gi + DATA_W + 1 +: 2];
      assign row[gi]   = addr_bus[AW*gi +: RW];
    end

    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [3:0]        r_reqs;
      logic [3:0]        w_reqs;
      logic [1:0]        r_win;
      logic [1:0]        w_win;
      logic              r_multi;
      logic              w_multi;
      logic              r_do;
      logic              w_do;
      logic [RW-1:0]     r_row;
      logic [RW-1:0]     w_row;
      logic [DATA_W-1:0] w_data;
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] rdata_reg;

      always_comb begin
        r_reqs = '0;
        w_reqs = '0;
        for (int p = 0; p < 4; p++) begin
          r_reqs[p] = ren[p] && (r_sel[p] == 2'(gi));
          w_reqs[p] = wen[p] && (w_sel[p] == 2'(gi));
        end
      end

      // More than one bit set means two or more requesters of that type.
      assign r_multi = (r_reqs & (r_reqs - 4'd1)) != 4'd0;
      assign w_multi = (w_reqs & (w_reqs - 4'd1)) != 4'd0;

`ifdef LSU_XBAR_RR_ARB_EN
      logic [1:0] r_ptr_reg;
      logic [1:0] w_ptr_reg;

      // Scan downward so the first requester at or after the pointer is kept.
      always_comb begin
        r_win = r_ptr_reg;
        w_win = w_ptr_reg;
        for (int k = 3; k >= 0; k--) begin
          if (r_reqs[r_ptr_reg + 2'(k)]) r_win = r_ptr_reg + 2'(k);
          if (w_reqs[w_ptr_reg + 2'(k)]) w_win = w_ptr_reg + 2'(k);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ptr_reg <= 2'd0;
          w_ptr_reg <= 2'd0;
        end else begin
          if (r_multi) r_ptr_reg <= r_win + 2'd1;
          if (w_multi) w_ptr_reg <= w_win + 2'd1;
        end
      end
`else
      always_comb begin
        r_win = 2'd0;
        w_win = 2'd0;
        for (int k = 3; k >= 0; k--) begin
          if (r_reqs[k]) r_win = 2'(k);
          if (w_reqs[k]) w_win = 2'(k);
        end
      end
`endif

      assign r_do   = |r_reqs;
      assign w_do   = (|w_reqs) && !rst;
      assign r_row  = row[r_win];
      assign w_row  = row[w_win];
      assign w_data = wdata[w_win];

      assign r_grant[gi]      = r_do ? (4'b0001 << r_win) : 4'b0000;
      assign conflict_now[gi] = r_multi || w_multi;

      // Read and write in the same process: a same-row collision returns the old word.
      always_ff @(posedge clk) begin
        if (w_do) mem[w_row] <= w_data;
        if (r_do) rdata_reg <= mem[r_row];
      end

      assign bank_rdata[gi] = rdata_reg;
    end
  endgenerate

  always_comb begin
    rd_valid_next = '0;
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 4; b++) begin
        rd_valid_next[p] = rd_valid_next[p] | r_grant[b][p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg      <= '0;
      rd_bank_reg       <= '0;
      conflict_flag_reg <= '0;
    end else begin
      rd_valid_reg      <= rd_valid_next;
      rd_bank_reg       <= r_sel;
      conflict_flag_reg <= (conflict_clr ? 4'b0000 : conflict_flag_reg) | conflict_now;
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_out
      assign cbg_to_lsu[OQ*gi +: OQ] = {rd_valid_reg[gi],
                                        rd_valid_reg[gi] ? bank_rdata[rd_bank_reg[gi]] : {DATA_W{1'b0}}};
    end
  endgenerate

  assign conflict_flag = conflict_flag_reg;

endmodule

// File: tb/tb_lsu_bank_xbar.sv
// Self-checking bench for lsu_bank_xbar: directed scenarios plus randomized traffic against a bank/arbitration model.
module tb_lsu_bank_xbar;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1024;
  localparam int DATA_W = 32;
  localparam int AW     = ADDR_W + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   r_req;
  logic [139:0]  w_req;
  logic [4*AW-1:0] addr_bus;
  logic [131:0]  cbg_to_lsu;
  logic [3:0]    conflict_flag;
  logic          conflict_clr;

  logic          ren_t   [4];
  logic [1:0]    rsel_t  [4];
  logic          wen_t   [4];
  logic [1:0]    wsel_t  [4];
  logic [31:0]   wdata_t [4];
  logic [AW-1:0] addr_t  [4];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [31:0]  mdl_mem [4][DEPTH];
  logic [131:0] exp_out  = '0;
  logic [3:0]   exp_flag = '0;
  int           r_ptr [4] = '{0, 0, 0, 0};
  int           w_ptr [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  lsu_bank_xbar #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .r_req(r_req),
    .w_req(w_req),
    .addr_bus(addr_bus),
    .cbg_to_lsu(cbg_to_lsu),
    .conflict_flag(conflict_flag),
    .conflict_clr(conflict_clr)
  );

  always_comb begin
    r_req    = '0;
    w_req    = '0;
    addr_bus = '0;
    for (int p = 0; p < 4; p++) begin
      r_req[3*p +: 3]     = {rsel_t[p], ren_t[p]};
      w_req[35*p +: 35]   = {wsel_t[p], wen_t[p], wdata_t[p]};
      addr_bus[AW*p +: AW] = addr_t[p];
    end
  end

  function automatic int pick(logic [3:0] req, int start);
    for (int k = 0; k < 4; k++) begin
      if (req[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  // Reference model: per edge, pick winners from the request sets, read old contents, then apply writes.
  initial forever begin : model
    logic [3:0]   rq, wq, conf, wb_en;
    logic [131:0] nxt;
    int           rw, ww, rs, ws;
    int           wb_row [4];
    logic [31:0]  wb_data [4];
    @(posedge clk);
    if (rst) begin
      exp_out  = '0;
      exp_flag = '0;
      for (int b = 0; b < 4; b++) begin
        r_ptr[b] = 0;
        w_ptr[b] = 0;
      end
    end else begin
      nxt   = '0;
      conf  = '0;
      wb_en = '0;
      for (int b = 0; b < 4; b++) begin
        rq = '0;
        wq = '0;
        for (int p = 0; p < 4; p++) begin
          rq[p] = ren_t[p] && (int'(rsel_t[p]) == b);
          wq[p] = wen_t[p] && (int'(wsel_t[p]) == b);
        end
`ifdef LSU_XBAR_RR_ARB_EN
        rs = r_ptr[b];
        ws = w_ptr[b];
`else
        rs = 0;
        ws = 0;
`endif
        rw = pick(rq, rs);
        ww = pick(wq, ws);
        if (rw >= 0) nxt[33*rw +: 33] = {1'b1, mdl_mem[b][int'(addr_t[rw]) % DEPTH]};
        if (ww >= 0) begin
          wb_en[b]   = 1'b1;
          wb_row[b]  = int'(addr_t[ww]) % DEPTH;
          wb_data[b] = wdata_t[ww];
        end
        if ($countones(rq) > 1 || $countones(wq) > 1) conf[b] = 1'b1;
        if ($countones(rq) > 1) r_ptr[b] = (rw + 1) % 4;
        if ($countones(wq) > 1) w_ptr[b] = (ww + 1) % 4;
      end
      for (int b = 0; b < 4; b++) begin
        if (wb_en[b]) mdl_mem[b][wb_row[b]] = wb_data[b];
      end
      exp_out  = nxt;
      exp_flag = (conflict_clr ? 4'b0000 : exp_flag) | conf;
    end
  end

  initial forever begin : compare
    @(negedge clk);
    if (cmp_en) begin
      checks++;
      if (cbg_to_lsu !== exp_out) begin
        errors++;
        $display("FAIL model_out: got %h expected %h", cbg_to_lsu, exp_out);
      end
      checks++;
      if (conflict_flag !== exp_flag) begin
        errors++;
        $display("FAIL model_flag: got %b expected %b", conflict_flag, exp_flag);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(string name, logic [131:0] got, logic [131:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  function automatic logic [32:0] slot(int p);
    return cbg_to_lsu[33*p +: 33];
  endfunction

  task automatic idle();
    for (int p = 0; p < 4; p++) begin
      ren_t[p]   = 1'b0;
      rsel_t[p]  = 2'd0;
      wen_t[p]   = 1'b0;
      wsel_t[p]  = 2'd0;
      wdata_t[p] = 32'h0;
      addr_t[p]  = '0;
    end
    conflict_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(int p, int b, logic [AW-1:0] a);
    ren_t[p]  = 1'b1;
    rsel_t[p] = 2'(b);
    addr_t[p] = a;
  endtask

  task automatic wr(int p, int b, logic [AW-1:0] a, logic [31:0] d);
    wen_t[p]   = 1'b1;
    wsel_t[p]  = 2'(b);
    addr_t[p]  = a;
    wdata_t[p] = d;
  endtask

  initial begin : driver
    logic [131:0] e;
    idle();
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_out", cbg_to_lsu, '0);
    chk("reset_flag", 132'(conflict_flag), '0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    for (int r = 0; r < 16; r++) begin
      idle();
      for (int p = 0; p < 4; p++) wr(p, p, AW'(r), $urandom);
      tick();
    end
    idle();

    wr(0, 2, AW'(5), 32'hDEADBEEF);
    tick(); idle();
    rd(3, 2, AW'(5));
    tick(); idle();
    e = '0;
    e[99 +: 33] = 33'h1DEADBEEF;
    chk("wr_then_rd", cbg_to_lsu, e);
    $display("txn write-then-read port3 bank2 row5 out=%h", slot(3));

    wr(0, 0, AW'(7), 32'hA5);
    tick(); idle();
    wr(1, 0, AW'(7), 32'h1);
    rd(2, 0, AW'(7));
    tick(); idle();
    chk("read_first_old", 132'(slot(2)), 132'(33'h1000000A5));
    rd(2, 0, AW'(7));
    tick(); idle();
    chk("read_after_write", 132'(slot(2)), 132'(33'h100000001));
    $display("txn read-first collision bank0 row7 out=%h", slot(2));

    rd(0, 1, AW'(3));
    rd(2, 1, AW'(3));
    tick(); idle();
    chk("rd_conflict_winner_valid", 132'(slot(0) >> 32), 132'(1));
    chk("rd_conflict_loser_zero", 132'(slot(2)), '0);
    chk("rd_conflict_flag", 132'(conflict_flag), 132'(4'b0010));
    conflict_clr = 1'b1;
    tick(); idle();
    chk("flag_cleared", 132'(conflict_flag), '0);
    $display("txn read conflict bank1 then clear flag=%b", conflict_flag);

    wr(1, 3, AW'(0), 32'h11);
    wr(3, 3, AW'(0), 32'h33);
    tick(); idle();
    rd(0, 3, AW'(0));
    tick(); idle();
    chk("wr_conflict_first", 132'(slot(0)), 132'(33'h100000011));
    wr(1, 3, AW'(0), 32'h11);
    wr(3, 3, AW'(0), 32'h33);
    tick(); idle();
    rd(0, 3, AW'(0));
    tick(); idle();
`ifdef LSU_XBAR_RR_ARB_EN
    chk("wr_conflict_second", 132'(slot(0)), 132'(33'h100000033));
`else
    chk("wr_conflict_second", 132'(slot(0)), 132'(33'h100000011));
`endif
    conflict_clr = 1'b1;
    tick(); idle();
    $display("txn write conflict bank3 row0 out=%h", slot(0));

    wr(1, 1, {2'b01, 16'd0}, 32'hCAFE0001);
    tick(); idle();
    rd(1, 1, {2'b00, 16'd1024});
    tick(); idle();
    chk("alias_row0", 132'(slot(1)), 132'(33'h1CAFE0001));
    wr(2, 1, {2'b00, 16'd1025}, 32'hCAFE0002);
    tick(); idle();
    rd(2, 1, {2'b00, 16'd1});
    tick(); idle();
    chk("alias_row1", 132'(slot(2)), 132'(33'h1CAFE0002));
    $display("txn address alias bank1 out=%h", slot(2));

    rd(0, 2, AW'(0));
    rd(1, 2, AW'(0));
    tick(); idle();
    rd(3, 0, AW'(7));
    tick(); idle();
    rst = 1'b1;
    rd(2, 0, AW'(7));
    wr(0, 0, AW'(7), 32'hBAD);
    tick(); idle();
    chk("rst_out_zero", cbg_to_lsu, '0);
    chk("rst_flag_zero", 132'(conflict_flag), '0);
    rst = 1'b0;
    rd(2, 0, AW'(7));
    tick(); idle();
    chk("rst_write_blocked", 132'(slot(2)), 132'(33'h100000001));
    $display("txn reset mid-operation out=%h", slot(2));

    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 4; p++) begin
        ren_t[p]   = ($urandom_range(0, 2) != 0);
        rsel_t[p]  = 2'($urandom);
        wen_t[p]   = ($urandom_range(0, 2) == 0);
        wsel_t[p]  = 2'($urandom);
        wdata_t[p] = $urandom;
        addr_t[p]  = {8'($urandom), 10'($urandom_range(0, 15))};
      end
      conflict_clr = ($urandom_range(0, 7) == 0);
      rst          = ($urandom_range(0, 99) == 0);
      tick();
      $display("txn %0d rst=%0b r_req=%h out=%h flag=%b", i, rst, r_req, cbg_to_lsu, conflict_flag);
    end
    idle();
    rst = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
